dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//   Load/store initiator for the word-organised data memory. Accepts one CPU
//   load/store at a time, drives the memory's addr/din/WR_RD port, absorbs its
//   registered-address read latency, does byte/half extraction, sign extension
//   and read-modify-write for sub-word stores, and returns a response pulse.
// PARAMETERS
//   DATA_WIDTH  32  memory word width; byte-lane logic is fixed for 32
//   ADDR_WIDTH  10  memory word-address width (1024 words)
// PORTS
//   clk         in   1           clock, all state changes on rising edge
//   rst         in   1           asynchronous, active-low reset
//   req_valid   in   1           request present
//   req_ready   out  1           1 only in IDLE; request accepted when both are 1
//   req_we      in   1           1=store, 0=load
//   req_size    in   2           00 byte, 01 half, 10 word, 11 illegal (error)
//   req_signed  in   1           loads: 1 sign-extend, 0 zero-extend
//   req_addr    in   32          byte address
//   req_wdata   in   32          store data, right-justified for byte/half
//   rsp_valid   out  1           one-cycle completion pulse, no backpressure
//   rsp_rdata   out  32          load result; 0 for stores and errors
//   rsp_err     out  1           misaligned, out-of-range or illegal size
//   mem_addr    out  ADDR_WIDTH  word address = req_addr[ADDR_WIDTH+1:2]
//   mem_din     out  DATA_WIDTH  write data to memory
//   mem_wr_rd   out  1           0 = write this edge, 1 = read (default)
//   mem_dout    in   DATA_WIDTH  memory read data, valid the cycle after mem_addr
// BEHAVIOUR
//   - Reset (rst=0): state IDLE, mem_wr_rd=1, mem_addr=0, mem_din=0,
//     rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready=1. All outputs registered;
//     mem_wr_rd forced to 1 asynchronously so no write occurs under reset.
//   - Request fields latched at acceptance; inputs ignored outside IDLE.
//   - Errors: word with addr[1:0]!=0, half with addr[0]=1, size 11, or
//     req_addr[31:ADDR_WIDTH+2]!=0 -> no memory access, IDLE->RESP, rsp_err=1.
//   - Little-endian lanes: byte k = bits [8k+7:8k], k=addr[1:0]; half at
//     addr[1]=0 low 16 bits, addr[1]=1 high 16 bits.
//   - FSM: IDLE, RD_ADDR, RD_DATA, WR, RESP.
//     load:          IDLE->RD_ADDR->RD_DATA->RESP->IDLE
//     word store:    IDLE->WR->RESP->IDLE
//     sub-word store:IDLE->RD_ADDR->RD_DATA->WR->RESP->IDLE
//     error:         IDLE->RESP->IDLE
//   - RD_ADDR: mem_addr driven, mem_wr_rd=1. RD_DATA: mem_dout sampled at the
//     end of the cycle (load: extract+extend; store: merge new lane(s) into word).
//   - WR: mem_wr_rd=0 for exactly one cycle, mem_din = full/merged word;
//     mem_wr_rd=1 in every other state.
//   - RESP: rsp_valid=1 one cycle with rsp_rdata/rsp_err; cleared next cycle.
//   - Latency from accepting edge to rsp_valid high: error 1, word store 2,
//     load 3, sub-word store 4 cycles. Throughput: next request accepted in the
//     cycle after RESP (back-to-back allowed once IDLE).
//   - Reset mid-operation: transaction dropped, no response, no pending write
//     issued; IDLE after release.
// TESTING (bench models word memory with registered read address)
//   1 rst=0 for 3 cycles -> mem_wr_rd=1, rsp_valid=0, req_ready=1; release idle.
//   2 store word 0xDEADBEEF @0x10 -> mem_addr=4, mem_wr_rd=0 one cycle,
//     rsp_valid at +2 err=0; load word @0x10 -> rsp_rdata=0xDEADBEEF at +3.
//   3 word 0x80FF7F01 @0x20; load byte signed @0x23 -> 0xFFFFFF80; unsigned
//     -> 0x00000080; load half signed @0x20 -> 0x00007F01.
//   4 word 0x11223344 @0x30; store byte 0xAB @0x31 -> single write 0x1122AB44,
//     rsp_valid at +4; reload word -> 0x1122AB44.
//   5 load word @0x12, store half @0x15, size 11, addr 0x1000 -> each rsp_err=1
//     at +1, rsp_rdata=0, mem_wr_rd never 0.
//   6 rst=0 during RD_DATA of byte store -> no write cycle, no rsp_valid,
//     req_ready=1 after release; memory word unchanged.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Load/store initiator for a word-organised data memory with registered read.
// Handles sub-word extraction, sign extension and read-modify-write stores.
module dmem_access_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_wr_rd,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR,
    S_RESP
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  state_t                  state_q;
  logic                    ready_q;
  logic                    we_q;
  logic [1:0]              size_q;
  logic                    signed_q;
  logic [1:0]              off_q;
  logic [15:0]             wdata_q;
  logic                    rsp_valid_q;
  logic [31:0]             rsp_rdata_q;
  logic                    rsp_err_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_din_q;
  logic                    wr_rd_q;

  logic        req_err_d;
  logic [7:0]  byte_d;
  logic [15:0] half_d;
  logic [31:0] load_d;
  logic [31:0] merged_d;

  always_comb begin
    req_err_d = 1'b0;
    unique case (1'b1)
      req_size == SZ_ILL:  req_err_d = 1'b1;
      req_size == SZ_WORD: req_err_d = |req_addr[1:0];
      req_size == SZ_HALF: req_err_d = req_addr[0];
      default:             req_err_d = 1'b0;
    endcase
    if (|req_addr[31:ADDR_WIDTH+2])
      req_err_d = 1'b1;
  end

  assign byte_d = mem_dout[{off_q, 3'b000} +: 8];
  assign half_d = off_q[1] ? mem_dout[31:16]
                           : mem_dout[15:0];

  always_comb begin
    load_d = mem_dout;
    unique case (1'b1)
      size_q == SZ_BYTE:
        load_d = {{24{signed_q & byte_d[7]}},
                  byte_d};
      size_q == SZ_HALF:
        load_d = {{16{signed_q & half_d[15]}},
                  half_d};
      default: load_d = mem_dout;
    endcase
  end

  // Only the addressed lane(s) change; the rest keep the word just read.
  always_comb begin
    merged_d = mem_dout;
    unique case (1'b1)
      size_q == SZ_BYTE:
        merged_d[{off_q, 3'b000} +: 8] =
          wdata_q[7:0];
      size_q == SZ_HALF:
        merged_d[{off_q[1], 4'b0000} +: 16] =
          wdata_q;
      default: merged_d = mem_dout;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      signed_q    <= 1'b0;
      off_q       <= 2'b00;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      wr_rd_q     <= 1'b1;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wr_rd_q     <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (req_valid && ready_q) begin
            ready_q  <= 1'b0;
            we_q     <= req_we;
            size_q   <= req_size;
            signed_q <= req_signed;
            off_q    <= req_addr[1:0];
            wdata_q  <= req_wdata[15:0];
            if (req_err_d) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else if (req_we &&
                         req_size == SZ_WORD) begin
              state_q    <= S_WR;
              wr_rd_q    <= 1'b0;
              mem_din_q  <= req_wdata;
              mem_addr_q <=
                req_addr[ADDR_WIDTH+1:2];
            end else begin
              state_q    <= S_RD_ADDR;
              mem_addr_q <=
                req_addr[ADDR_WIDTH+1:2];
            end
          end
        end
        S_RD_ADDR: state_q <= S_RD_DATA;
        S_RD_DATA: begin
          if (we_q) begin
            state_q   <= S_WR;
            wr_rd_q   <= 1'b0;
            mem_din_q <= merged_d;
          end else begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= load_d;
          end
        end
        S_WR: begin
          state_q     <= S_RESP;
          rsp_valid_q <= 1'b1;
        end
        S_RESP: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign mem_wr_rd = wr_rd_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: registered-read word memory plus a
// byte-level reference model of the load/store rules.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din;
  logic        mem_wr_rd;
  logic [31:0] mem_dout;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  logic [9:0]  raddr_q = '0;
  int          wr_count = 0;
  int          rsp_count = 0;
  logic [9:0]  last_wr_addr;
  logic [31:0] last_wr_data;

  dmem_access_ctrl #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_size(req_size),
    .req_signed(req_signed),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_addr(mem_addr),
    .mem_din(mem_din),
    .mem_wr_rd(mem_wr_rd),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  assign mem_dout = mem[raddr_q];

  always @(posedge clk) begin
    if (mem_wr_rd === 1'b0) begin
      mem[mem_addr] <= mem_din;
      wr_count++;
      last_wr_addr = mem_addr;
      last_wr_data = mem_din;
    end
    if (rsp_valid === 1'b1)
      rsp_count++;
    raddr_q <= mem_addr;
  end

  function automatic bit ref_err(
    input logic [1:0] size, input logic [31:0] addr);
    if (addr >= 32'd4096) return 1;
    if (size == 2'd3) return 1;
    if (size == 2'd2 && addr % 4 != 0) return 1;
    if (size == 2'd1 && addr % 2 != 0) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] ref_load(
    input logic [31:0] w, input logic [1:0] size,
    input logic sgn, input int off);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (sgn && v >= 32'd128) v = v - 32'd256;
    end else if (size == 2'd1) begin
      v = (w >> (16 * (off / 2))) & 32'hFFFF;
      if (sgn && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(
    input logic [31:0] w, input logic [1:0] size,
    input int off, input logic [31:0] wd);
    logic [7:0] b [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) b[i] = 8'((w >> (8 * i)) & 32'hFF);
    if (size == 2'd0) begin
      b[off] = wd[7:0];
    end else if (size == 2'd1) begin
      b[off]     = wd[7:0];
      b[off + 1] = wd[15:8];
    end else begin
      for (int i = 0; i < 4; i++) b[i] = 8'((wd >> (8 * i)) & 32'hFF);
    end
    r = 0;
    for (int i = 0; i < 4; i++) r = r | (32'(b[i]) << (8 * i));
    return r;
  endfunction

  task automatic txn(input logic we, input logic [1:0] size,
                     input logic sgn, input logic [31:0] addr,
                     input logic [31:0] wdata);
    bit          e;
    int          exp_lat;
    int          lat;
    int          w0;
    int          widx;
    int          off;
    logic [31:0] exp_rd;
    logic [31:0] exp_wr;
    e    = ref_err(size, addr);
    widx = int'(addr / 4) % 1024;
    off  = int'(addr % 4);
    exp_rd = 0;
    exp_wr = 0;
    if (e) exp_lat = 1;
    else if (we && size == 2'd2) exp_lat = 2;
    else if (we) exp_lat = 4;
    else exp_lat = 3;
    if (!e && !we) exp_rd = ref_load(ref_mem[widx], size, sgn, off);
    if (!e && we) exp_wr = ref_store(ref_mem[widx], size, off, wdata);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_req got=%b want=1", req_ready);
    end
    w0 = wr_count;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL latency addr=%h got=%0d want=%0d",
               addr, lat, exp_lat);
    end
    checks++;
    if (rsp_err !== e) begin
      errors++;
      $display("FAIL rsp_err addr=%h got=%b want=%b", addr, rsp_err, e);
    end
    checks++;
    if (rsp_rdata !== exp_rd) begin
      errors++;
      $display("FAIL rsp_rdata addr=%h sz=%0d got=%h want=%h",
               addr, size, rsp_rdata, exp_rd);
    end
    checks++;
    if (wr_count - w0 != ((we && !e) ? 1 : 0)) begin
      errors++;
      $display("FAIL write_cycles addr=%h got=%0d want=%0d",
               addr, wr_count - w0, (we && !e) ? 1 : 0);
    end
    if (we && !e) begin
      checks++;
      if (last_wr_addr !== 10'(widx) || last_wr_data !== exp_wr) begin
        errors++;
        $display("FAIL write_data got=%h@%h want=%h@%h",
                 last_wr_data, last_wr_addr, exp_wr, widx);
      end
      ref_mem[widx] = exp_wr;
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 0) begin
      errors++;
      $display("FAIL after_resp valid=%b ready=%b rdata=%h want 0/1/0",
               rsp_valid, req_ready, rsp_rdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (mem_wr_rd !== 1'b1 || rsp_valid !== 1'b0 ||
          req_ready !== 1'b1 || mem_addr !== 10'd0 ||
          rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL reset wr_rd=%b vld=%b rdy=%b addr=%h want 1/0/1/0",
                 mem_wr_rd, rsp_valid, req_ready, mem_addr);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_wr_rd !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset rdy=%b vld=%b wr_rd=%b want 1/0/1",
               req_ready, rsp_valid, mem_wr_rd);
    end
  endtask

  task automatic test_word();
    txn(1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
    checks++;
    if (last_wr_addr !== 10'd4) begin
      errors++;
      $display("FAIL word_store_addr got=%h want=004", last_wr_addr);
    end
    txn(0, 2'd2, 0, 32'h10, 32'h0);
  endtask

  task automatic test_byte_half_load();
    txn(1, 2'd2, 0, 32'h20, 32'h80FF7F01);
    txn(0, 2'd0, 1, 32'h23, 32'h0);
    txn(0, 2'd0, 0, 32'h23, 32'h0);
    txn(0, 2'd1, 1, 32'h20, 32'h0);
    txn(0, 2'd1, 1, 32'h22, 32'h0);
    txn(0, 2'd0, 1, 32'h21, 32'h0);
  endtask

  task automatic test_subword_store();
    txn(1, 2'd2, 0, 32'h30, 32'h11223344);
    txn(1, 2'd0, 0, 32'h31, 32'h000000AB);
    txn(0, 2'd2, 0, 32'h30, 32'h0);
    txn(1, 2'd1, 0, 32'h32, 32'hFFFF5566);
    txn(0, 2'd2, 0, 32'h30, 32'h0);
  endtask

  task automatic test_errors();
    txn(0, 2'd2, 0, 32'h12, 32'h0);
    txn(1, 2'd1, 0, 32'h15, 32'h12345678);
    txn(0, 2'd3, 0, 32'h20, 32'h0);
    txn(1, 2'd3, 0, 32'h20, 32'h0);
    txn(0, 2'd2, 0, 32'h1000, 32'h0);
    txn(1, 2'd2, 0, 32'h80000010, 32'hCAFEF00D);
  endtask

  task automatic test_reset_midop();
    int w0;
    int r0;
    w0 = wr_count;
    r0 = rsp_count;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'd0;
    req_addr  = 32'h31;
    req_wdata = 32'h000000CD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (mem_wr_rd !== 1'b1) begin
        errors++;
        $display("FAIL midop_wr_rd got=%b want=1", mem_wr_rd);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (wr_count != w0 || rsp_count != r0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midop writes=%0d rsps=%0d rdy=%b want 0/0/1",
               wr_count - w0, rsp_count - r0, req_ready);
    end
    checks++;
    if (mem[12] !== ref_mem[12]) begin
      errors++;
      $display("FAIL midop_mem got=%h want=%h", mem[12], ref_mem[12]);
    end
    txn(0, 2'd2, 0, 32'h30, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 250; i++) begin
      a = 32'h40 + ($urandom % 64);
      if ($urandom % 16 == 0) a = 32'h1000 + $urandom % 4096;
      txn(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
    end
  endtask

  task automatic test_memory_image();
    int bad;
    bad = 0;
    for (int i = 0; i < 1024; i++)
      if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL memory_image got=%0d differing words want=0", bad);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    test_reset();
    test_word();
    test_byte_half_load();
    test_subword_store();
    test_errors();
    test_reset_midop();
    test_random();
    test_memory_image();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
